// File: rtl/longlat_exec_sched.sv
// longlat_exec_sched
//   Scheduler for the multi-cycle MDU and FPU of the RV32IMF pipeline. It accepts one
//   long-latency op per idle unit from execute and sends the unit a registered one-cycle start
//   pulse. Each unit's result is caught in a holding register, and the two units share one
//   writeback port through a round-robin arbiter. Decode is stalled while it reads a register
//   that a live op will write.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   issue_valid/ready/unit/rd/rd_fp   op handshake from execute (unit: 0 = MDU, 1 = FPU)
//   flush                        kills every pending op
//   mdu_start/done/result        MDU interface
//   fpu_start/done/result/fflags FPU interface
//   wb_valid/ready/rd/rd_fp/data/fflags   shared long-latency writeback port
//   chk_rs1..3, chk_fp1..3       decode source registers to check for hazards
//   hazard_stall                 a decode source matches a pending destination

module longlat_exec_sched #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic            issue_unit,
  input  logic [REGW-1:0] issue_rd,
  input  logic            issue_rd_fp,
  input  logic            flush,
  output logic            mdu_start,
  input  logic            mdu_done,
  input  logic [XLEN-1:0] mdu_result,
  output logic            fpu_start,
  input  logic            fpu_done,
  input  logic [XLEN-1:0] fpu_result,
  input  logic [4:0]      fpu_fflags,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [REGW-1:0] wb_rd,
  output logic            wb_rd_fp,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_fflags,
  input  logic [REGW-1:0] chk_rs1,
  input  logic [REGW-1:0] chk_rs2,
  input  logic [REGW-1:0] chk_rs3,
  input  logic            chk_fp1,
  input  logic            chk_fp2,
  input  logic            chk_fp3,
  output logic            hazard_stall
);

  typedef enum logic [1:0] {StIdle, StBusy, StHold, StDrain} unit_state_e;

  unit_state_e mdu_st_q, mdu_st_d;
  unit_state_e fpu_st_q, fpu_st_d;

  logic            mdu_start_q, fpu_start_q;
  logic [REGW-1:0] mdu_rd_q, fpu_rd_q;
  logic            mdu_rd_fp_q, fpu_rd_fp_q;
  logic [XLEN-1:0] mdu_res_q, fpu_res_q;
  logic [4:0]      fpu_flags_q;
  logic            prio_q;      // 0 = MDU wins a tie, 1 = FPU
  logic            lock_q;      // a result was offered and stalled last cycle
  logic            lock_sel_q;  // unit offered in that stalled cycle

  logic mdu_acc, fpu_acc;
  logic mdu_hold, fpu_hold, both_hold;
  logic sel;                    // 0 = MDU drives writeback, 1 = FPU
  logic grant, mdu_grant, fpu_grant;

  // A done that arrives together with a flush finishes the killed op, so the unit goes straight
  // to IDLE. Sending it to DRAIN would leave it waiting for a done that never comes.
  function automatic unit_state_e unit_next(unit_state_e st, logic acc, logic done,
                                            logic grnt, logic kill);
    unit_state_e ns;
    ns = st;
    unique case (st)
      StIdle:  if (acc) ns = StBusy;
      StBusy: begin
        if (done)      ns = kill ? StIdle : StHold;
        else if (kill) ns = StDrain;
      end
      StHold:  if (kill || grnt) ns = StIdle;
      StDrain: if (done) ns = StIdle;
      default: ns = StIdle;
    endcase
    return ns;
  endfunction

  function automatic logic src_hit(logic [REGW-1:0] rs, logic rs_fp, logic [REGW-1:0] rd,
                                   logic rd_fp, logic live);
    // Integer x0 is hardwired to zero; f0 is a real register.
    return live && (rs == rd) && (rs_fp == rd_fp) && (rs_fp || (rs != '0));
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      mdu_st_q <= StIdle;
      fpu_st_q <= StIdle;
    end else begin
      mdu_st_q <= mdu_st_d;
      fpu_st_q <= fpu_st_d;
    end
  end

  // Next state
  always_comb begin
    mdu_st_d = unit_next(mdu_st_q, mdu_acc, mdu_done, mdu_grant, flush);
    fpu_st_d = unit_next(fpu_st_q, fpu_acc, fpu_done, fpu_grant, flush);
  end

  // Outputs and arbitration
  always_comb begin
    issue_ready = (issue_unit ? (fpu_st_q == StIdle) : (mdu_st_q == StIdle)) & ~flush;
    mdu_acc     = issue_valid & issue_ready & ~issue_unit;
    fpu_acc     = issue_valid & issue_ready & issue_unit;

    mdu_hold  = (mdu_st_q == StHold);
    fpu_hold  = (fpu_st_q == StHold);
    both_hold = mdu_hold & fpu_hold;

    // A stalled offer keeps its unit selected so wb_* cannot change under the consumer.
    if (lock_q)         sel = lock_sel_q;
    else if (both_hold) sel = prio_q;
    else                sel = fpu_hold;

    wb_valid  = mdu_hold | fpu_hold;
    grant     = wb_valid & wb_ready & ~flush;
    mdu_grant = grant & ~sel;
    fpu_grant = grant & sel;

    wb_rd     = '0;
    wb_rd_fp  = 1'b0;
    wb_data   = '0;
    wb_fflags = '0;
    if (wb_valid) begin
      if (sel) begin
        wb_rd     = fpu_rd_q;
        wb_rd_fp  = fpu_rd_fp_q;
        wb_data   = fpu_res_q;
        wb_fflags = fpu_flags_q;
      end else begin
        wb_rd     = mdu_rd_q;
        wb_rd_fp  = mdu_rd_fp_q;
        wb_data   = mdu_res_q;
      end
    end

    mdu_start = mdu_start_q;
    fpu_start = fpu_start_q;

    hazard_stall =
        src_hit(chk_rs1, chk_fp1, mdu_rd_q, mdu_rd_fp_q, (mdu_st_q == StBusy) || mdu_hold)
      | src_hit(chk_rs2, chk_fp2, mdu_rd_q, mdu_rd_fp_q, (mdu_st_q == StBusy) || mdu_hold)
      | src_hit(chk_rs3, chk_fp3, mdu_rd_q, mdu_rd_fp_q, (mdu_st_q == StBusy) || mdu_hold)
      | src_hit(chk_rs1, chk_fp1, fpu_rd_q, fpu_rd_fp_q, (fpu_st_q == StBusy) || fpu_hold)
      | src_hit(chk_rs2, chk_fp2, fpu_rd_q, fpu_rd_fp_q, (fpu_st_q == StBusy) || fpu_hold)
      | src_hit(chk_rs3, chk_fp3, fpu_rd_q, fpu_rd_fp_q, (fpu_st_q == StBusy) || fpu_hold)
      | src_hit(chk_rs1, chk_fp1, issue_rd, issue_rd_fp, mdu_acc | fpu_acc)
      | src_hit(chk_rs2, chk_fp2, issue_rd, issue_rd_fp, mdu_acc | fpu_acc)
      | src_hit(chk_rs3, chk_fp3, issue_rd, issue_rd_fp, mdu_acc | fpu_acc);
  end

  // Datapath and arbiter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mdu_start_q <= 1'b0;
      fpu_start_q <= 1'b0;
      mdu_rd_q    <= '0;
      fpu_rd_q    <= '0;
      mdu_rd_fp_q <= 1'b0;
      fpu_rd_fp_q <= 1'b0;
      mdu_res_q   <= '0;
      fpu_res_q   <= '0;
      fpu_flags_q <= '0;
      prio_q      <= 1'b0;
      lock_q      <= 1'b0;
      lock_sel_q  <= 1'b0;
    end else begin
      mdu_start_q <= mdu_acc;
      fpu_start_q <= fpu_acc;
      if (mdu_acc) begin
        mdu_rd_q    <= issue_rd;
        mdu_rd_fp_q <= issue_rd_fp;
      end
      if (fpu_acc) begin
        fpu_rd_q    <= issue_rd;
        fpu_rd_fp_q <= issue_rd_fp;
      end
      if ((mdu_st_q == StBusy) && mdu_done) mdu_res_q <= mdu_result;
      if ((fpu_st_q == StBusy) && fpu_done) begin
        fpu_res_q   <= fpu_result;
        fpu_flags_q <= fpu_fflags;
      end
      // Round robin only moves when both units were competing.
      if (grant && both_hold) prio_q <= ~sel;
      lock_q     <= wb_valid & ~wb_ready & ~flush;
      lock_sel_q <= sel;
    end
  end

endmodule
